// File: rtl/line_sensor_reader.sv
// line_sensor_reader
//   Front end for three RC-discharge reflectance sensors. Each scan charges the sensor nodes,
//   releases them and times how long each node takes to read low. A long decay means a dark
//   surface (line) and a short decay means a light floor. Each channel is thresholded into a raw
//   bit, then debounced across scans into a filtered bit (0 = dark line, 1 = light floor).
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   sens_in[2:0]         raw sensor pins, [2]=left [1]=middle [0]=right, asynchronous
//   sens_oe[2:0]         1 = drive sensor node high (charge), 0 = release (high-Z)
//   sensors_raw[2:0]     unfiltered per-scan classification, 1 = light
//   scan_done            one-cycle pulse when sensors_raw and the filtered bits update
//   sensorLeftFiltered   filtered left channel
//   sensorMiddleFiltered filtered middle channel
//   sensorRightFiltered  filtered right channel
module line_sensor_reader #(
  parameter int unsigned CHARGE_CYCLES  = 500,
  parameter int unsigned TIMEOUT_CYCLES = 150000,
  parameter int unsigned THRESH         = 25000,
  parameter int unsigned FILT_LEN       = 4,
  parameter int unsigned CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sens_in,
  output logic [2:0] sens_oe,
  output logic [2:0] sensors_raw,
  output logic       scan_done,
  output logic       sensorLeftFiltered,
  output logic       sensorMiddleFiltered,
  output logic       sensorRightFiltered
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCharge = 2'd1;
  localparam logic [1:0] StDecay  = 2'd2;
  localparam logic [1:0] StEval   = 2'd3;

  // Disagree counter only ever holds 0..FILT_LEN-1; it clears on the flip.
  localparam int unsigned FCW = (FILT_LEN <= 2) ? 1 : $clog2(FILT_LEN);

  localparam logic [CNT_W-1:0] ChargeLast  = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ThreshVal   = CNT_W'(THRESH);
  localparam logic [FCW-1:0]   FiltLast    = FCW'(FILT_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lat_q, lat_d;
  logic [CNT_W-1:0] lval_q [3];
  logic [CNT_W-1:0] lval_d [3];
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       raw_q, raw_d;
  logic [2:0]       filt_q, filt_d;
  logic [FCW-1:0]   fcnt_q [3];
  logic [FCW-1:0]   fcnt_d [3];
  logic             done_q, done_d;
  logic             timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    raw_d   = raw_q;
    filt_d  = filt_q;
    done_d  = 1'b0;
    timeout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lval_d[i] = lval_q[i];
      fcnt_d[i] = fcnt_q[i];
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        lat_d = '0;
        for (int i = 0; i < 3; i++) lval_d[i] = '0;
        state_d = StCharge;
      end

      StCharge: begin
        if (cnt_q == ChargeLast) begin
          cnt_d   = '0;
          state_d = StDecay;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDecay: begin
        timeout = (cnt_q == TimeoutLast);
        cnt_d   = cnt_q + 1'b1;
        // First low sample latches the count; a timeout in the same cycle takes precedence.
        for (int i = 0; i < 3; i++) begin
          if (!lat_q[i]) begin
            if (timeout) begin
              lat_d[i]  = 1'b1;
              lval_d[i] = TimeoutVal;
            end else if (!sync2_q[i]) begin
              lat_d[i]  = 1'b1;
              lval_d[i] = cnt_q;
            end
          end
        end
        // Results are registered on the way into EVAL so they, and scan_done, are valid there.
        if (timeout || (&lat_d)) begin
          state_d = StEval;
          done_d  = 1'b1;
          for (int i = 0; i < 3; i++) begin
            raw_d[i] = (lval_d[i] < ThreshVal);
            if (raw_d[i] == filt_q[i]) begin
              fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FiltLast) begin
              filt_d[i] = ~filt_q[i];
              fcnt_d[i] = '0;
            end else begin
              fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
          end
        end
      end

      StEval: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      raw_q   <= 3'b111;
      filt_q  <= 3'b111;
      done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        lval_q[i] <= '0;
        fcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      sync1_q <= sens_in;
      sync2_q <= sync1_q;
      raw_q   <= raw_d;
      filt_q  <= filt_d;
      done_q  <= done_d;
      for (int i = 0; i < 3; i++) begin
        lval_q[i] <= lval_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  // Decoded straight from the state flop so reset releases the pads without a clock edge.
  assign sens_oe              = (state_q == StCharge) ? 3'b111 : 3'b000;
  assign sensors_raw          = raw_q;
  assign scan_done            = done_q;
  assign sensorLeftFiltered   = filt_q[2];
  assign sensorMiddleFiltered = filt_q[1];
  assign sensorRightFiltered  = filt_q[0];

endmodule
